// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with pending-write scoreboard.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit vector: one pending flag per register, set by Reserve, cleared by a write.
// Builds with REGFILE_BYPASS_EN expose the post-edge view to the read ports.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [(2**ADDR_W)-1:0] busy_rd
);
  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a new producer reserving in the same
  // cycle as the old producer's write keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef REGFILE_BYPASS_EN
  assign busy_rd = busy_d;
`else
  assign busy_rd = busy_q;
`endif
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with registered reads and per-register busy flags.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy state to reads.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveRegister,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              RdValid,
  output logic              Busy1,
  output logic              Busy2
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy_rd;
  logic              write_eff;
  logic              hit1;
  logic              hit2;

  // Register 0 never takes a write when hardwired, so it stays at its reset value.
  assign write_eff = RegWrite && !((ZERO_REG != 0) && (WriteRegister == '0));

`ifdef REGFILE_BYPASS_EN
  assign hit1 = write_eff && (WriteRegister == ReadRegister1);
  assign hit2 = write_eff && (WriteRegister == ReadRegister2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .set_en   (Reserve),
    .set_addr (ReserveRegister),
    .clr_en   (RegWrite),
    .clr_addr (WriteRegister),
    .busy_rd  (busy_rd)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (write_eff) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Read pipeline: outputs hold their last result while RdEn is low.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ReadData1 <= '0;
      ReadData2 <= '0;
      Busy1     <= 1'b0;
      Busy2     <= 1'b0;
      RdValid   <= 1'b0;
    end else begin
      RdValid <= RdEn;
      if (RdEn) begin
        ReadData1 <= hit1 ? WriteData : regs[ReadRegister1];
        ReadData2 <= hit2 ? WriteData : regs[ReadRegister2];
        Busy1     <= busy_rd[ReadRegister1];
        Busy2     <= busy_rd[ReadRegister2];
      end
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one instance with ZERO_REG=1 and one with ZERO_REG=0,
// both driven identically and checked against a per-instance array model.
module tb_regfile_scoreboard;
  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [4:0]  rd_a1, rd_a2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        res;
  logic [4:0]  ra;

  logic [31:0] o_d1 [2];
  logic [31:0] o_d2 [2];
  logic        o_v  [2];
  logic        o_b1 [2];
  logic        o_b2 [2];

  logic [31:0] m_reg  [2][32];
  logic        m_busy [2][32];
  logic [31:0] e_d1 [2];
  logic [31:0] e_d2 [2];
  logic        e_b1 [2];
  logic        e_b2 [2];
  logic        e_v;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
    .Clk(clk), .Rst_n(rst_n), .RdEn(rd_en),
    .ReadRegister1(rd_a1), .ReadRegister2(rd_a2),
    .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .Reserve(res), .ReserveRegister(ra),
    .ReadData1(o_d1[0]), .ReadData2(o_d2[0]), .RdValid(o_v[0]),
    .Busy1(o_b1[0]), .Busy2(o_b2[0])
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_n (
    .Clk(clk), .Rst_n(rst_n), .RdEn(rd_en),
    .ReadRegister1(rd_a1), .ReadRegister2(rd_a2),
    .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .Reserve(res), .ReserveRegister(ra),
    .ReadData1(o_d1[1]), .ReadData2(o_d2[1]), .RdValid(o_v[1]),
    .Busy1(o_b1[1]), .Busy2(o_b2[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_z%0d_data1", tag, 1 - k), o_d1[k], e_d1[k]);
      chk($sformatf("%s_z%0d_data2", tag, 1 - k), o_d2[k], e_d2[k]);
      chk($sformatf("%s_z%0d_busy1", tag, 1 - k), {31'd0, o_b1[k]}, {31'd0, e_b1[k]});
      chk($sformatf("%s_z%0d_busy2", tag, 1 - k), {31'd0, o_b2[k]}, {31'd0, e_b2[k]});
      chk($sformatf("%s_z%0d_valid", tag, 1 - k), {31'd0, o_v[k]}, {31'd0, e_v});
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[k][r]  = '0;
        m_busy[k][r] = 1'b0;
      end
      e_d1[k] = '0; e_d2[k] = '0; e_b1[k] = 1'b0; e_b2[k] = 1'b0;
    end
    e_v = 1'b0;
  endfunction

  // Value a read port returns given the model state before the edge and the
  // write/reserve happening at that edge.
  function automatic void model_read(input int k, input logic [4:0] a,
                                     output logic [31:0] d, output logic b);
    if (k == 0 && a == 0) begin
      d = '0;
      b = 1'b0;
    end else begin
      d = m_reg[k][a];
      b = m_busy[k][a];
`ifdef REGFILE_BYPASS_EN
      if (we && wa == a) begin
        d = wd;
        b = 1'b0;
      end
      if (res && ra == a) b = 1'b1;
`endif
    end
  endfunction

  function automatic void model_update(input int k);
    if (we && !(k == 0 && wa == 0)) begin
      m_reg[k][wa]  = wd;
      m_busy[k][wa] = 1'b0;
    end
    if (res && !(k == 0 && ra == 0)) m_busy[k][ra] = 1'b1;
  endfunction

  task automatic step(input logic rden, input logic [4:0] a1, input logic [4:0] a2,
                      input logic w, input logic [4:0] waddr, input logic [31:0] wdata,
                      input logic r, input logic [4:0] raddr, input string tag);
    logic [31:0] d;
    logic        b;
    @(negedge clk);
    rd_en = rden; rd_a1 = a1; rd_a2 = a2;
    we = w; wa = waddr; wd = wdata;
    res = r; ra = raddr;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rden) begin
        model_read(k, a1, d, b); e_d1[k] = d; e_b1[k] = b;
        model_read(k, a2, d, b); e_d2[k] = d; e_b2[k] = b;
      end
    end
    e_v = rden;
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    rd_en = 0; rd_a1 = 0; rd_a2 = 0; we = 0; wa = 0; wd = 0; res = 0; ra = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 5'd3, 5'd7, 0, 0, 0, 0, 0, "rst_read");
    step(1, 5'd3, 5'd7, 1, 5'd5, 32'hDEADBEEF, 0, 0, "wr_r5");
    step(1, 5'd5, 5'd5, 0, 0, 0, 0, 0, "rd_r5");
    step(0, 5'd1, 5'd2, 0, 0, 0, 1, 5'd9, "rsv_r9_hold");
    step(1, 5'd9, 5'd5, 0, 0, 0, 0, 0, "rd_r9_busy");
    step(1, 5'd9, 5'd9, 1, 5'd9, 32'h11, 0, 0, "wr_r9");
    step(1, 5'd9, 5'd9, 0, 0, 0, 0, 0, "rd_r9_done");
    step(1, 5'd4, 5'd9, 1, 5'd4, 32'h22, 1, 5'd4, "collide_r4");
    step(1, 5'd4, 5'd4, 0, 0, 0, 0, 0, "rd_r4");
    step(1, 5'd6, 5'd0, 1, 5'd6, 32'h1, 0, 0, "wr_r6_1");
    step(1, 5'd6, 5'd4, 1, 5'd6, 32'h2, 0, 0, "bypass_r6");
    step(1, 5'd6, 5'd6, 0, 0, 0, 0, 0, "rd_r6");
    step(1, 5'd4, 5'd4, 1, 5'd4, 32'h33, 1, 5'd4, "bypass_collide_r4");
    step(1, 5'd0, 5'd6, 1, 5'd0, 32'hFFFF, 1, 5'd0, "wr_rsv_r0");
    step(1, 5'd0, 5'd0, 0, 0, 0, 0, 0, "rd_r0");
    step(0, 5'd5, 5'd9, 1, 5'd5, 32'h55, 0, 0, "hold");
    step(1, 5'd31, 5'd5, 1, 5'd31, 32'hA5A5A5A5, 1, 5'd30, "top_addr");
    step(1, 5'd31, 5'd30, 0, 0, 0, 0, 0, "rd_top");

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom(),
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 15)), "rand");
    end

    // Reset asserted mid-cycle with a read and write in flight.
    @(negedge clk);
    rd_en = 1; rd_a1 = 5'd10; rd_a2 = 5'd5; we = 1; wa = 5'd10; wd = 32'hCAFE; res = 1; ra = 5'd10;
    #2 rst_n = 1'b0;
    model_clear();
    #1 check_all("async_rst");
    @(posedge clk);
    #1 check_all("in_reset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    step(0, 5'd10, 5'd5, 0, 0, 0, 0, 0, "post_rst_idle");
    step(1, 5'd10, 5'd5, 0, 0, 0, 0, 0, "post_rst_read");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
